// File: rtl/mc_dp_pkg.sv
// Shared encodings for the multicycle datapath and its memory sequencer.
package mc_dp_pkg;

    localparam int INSTR_BYTES = 2;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_A     = 2'd2,
        SRCA_ZERO  = 2'd3
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_B     = 2'd0,
        SRCB_IMM   = 2'd1,
        SRCB_INSTR = 2'd2,
        SRCB_ZERO  = 2'd3
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_MDR    = 2'd1,
        RES_ALU    = 2'd2,
        RES_IMM    = 2'd3
    } result_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_e;

    // LONG: sext {IR[15],IR[11:0]}; SHORT: sext {IR[15],IR[5:0]};
    // BRANCH: LONG shifted left by one; UPPER: zero-extended IR[11:0].
    typedef enum logic [2:0] {
        IMM_LONG   = 3'd0,
        IMM_SHORT  = 3'd1,
        IMM_BRANCH = 3'd2,
        IMM_UPPER  = 3'd3
    } imm_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_REQ  = 2'd1,
        SEQ_WAIT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mc_datapath_hs_mem_seq.sv
// Memory sequencer: launches one request/grant/rvalid access per mem_start
// and owns the registers filled by memory (MDR, IR, OldPC).
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   SEQ_IDLE | no access in flight, mem_start accepted
//   SEQ_REQ  | mem_req high, address/we/wdata held until mem_gnt
//   SEQ_WAIT | read granted, waiting for mem_rvalid
module mc_mem_seq
    import mc_dp_pkg::*;
#(
    parameter int XLEN   = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_start,
    input  logic              mem_write,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   pc,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [XLEN-1:0]   mdr,
    output logic [15:0]       ir,
    output logic [XLEN-1:0]   old_pc
);

    seq_state_e state;
    logic       ir_pend;

    assign mem_busy = (state != SEQ_IDLE);

    // Sequencer FSM with registered bus outputs and memory-loaded registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEQ_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_done  <= 1'b0;
            ir_pend   <= 1'b0;
            mdr       <= '0;
            ir        <= '0;
            old_pc    <= '0;
        end else begin
            mem_done <= 1'b0;
            unique case (state)
                SEQ_IDLE: begin
                    if (mem_start) begin
                        state     <= SEQ_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write;
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        ir_pend   <= ir_write;
                        if (ir_write) old_pc <= pc;
                    end
                end
                SEQ_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state    <= SEQ_IDLE;
                            mem_done <= 1'b1;
                        end else begin
                            state <= SEQ_WAIT;
                        end
                    end
                end
                SEQ_WAIT: begin
                    if (mem_rvalid) begin
                        mdr <= mem_rdata;
                        if (ir_pend) ir <= mem_rdata[15:0];
                        state    <= SEQ_IDLE;
                        mem_done <= 1'b1;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mc_datapath_hs.sv
// XLEN-bit multicycle datapath with a handshaked memory port.
module mc_datapath_hs
    import mc_dp_pkg::*;
#(
    parameter int              XLEN     = 16,
    parameter int              ADDR_W   = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter bit              ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              ir_write,
    input  logic              reg_write,
    input  logic              adr_src,
    input  logic              mem_write,
    input  logic [1:0]        result_src,
    input  logic [1:0]        alu_src_a,
    input  logic [1:0]        alu_src_b,
    input  logic [2:0]        alu_control,
    input  logic [2:0]        imm_src,
    input  logic              mem_start,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [2:0]        op,
    output logic [2:0]        funct3,
    output logic [1:0]        branch_funct,
    output logic              funct7,
    output logic              zero,
    output logic              less,
    output logic              greater,
    input  logic [2:0]        dbg_sel,
    output logic [XLEN-1:0]   dbg_data
);

    logic [XLEN-1:0] pc, old_pc, mdr, a_reg, b_reg, alu_out;
    logic [15:0]     ir;
    logic [XLEN-1:0] rf [8];
    logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;
    logic [12:0]     imm_raw;
    logic [2:0]      rs1, rs2, rd;
    logic [ADDR_W-1:0] seq_addr;

    assign rs1     = ir[5:3];
    assign rs2     = ir[8:6];
    assign rd      = ir[11:9];
    assign imm_raw = {ir[15], ir[11:0]};

    assign op           = ir[14:12];
    assign funct3       = ir[2:0];
    assign branch_funct = ir[11:10];
    assign funct7       = ir[15];

    // Register file reads, with register 0 hard-wired when ZERO_REG is set.
    always_comb begin
        rd1      = rf[rs1];
        rd2      = rf[rs2];
        dbg_data = rf[dbg_sel];
        if (ZERO_REG) begin
            if (rs1 == 3'd0)     rd1      = '0;
            if (rs2 == 3'd0)     rd2      = '0;
            if (dbg_sel == 3'd0) dbg_data = '0;
        end
    end

    // Immediate extension.
    always_comb begin
        imm_ext = {{(XLEN-13){imm_raw[12]}}, imm_raw};
        case (imm_e'(imm_src))
            IMM_SHORT:  imm_ext = {{(XLEN-7){ir[15]}}, ir[15], ir[5:0]};
            IMM_BRANCH: imm_ext = {{(XLEN-14){imm_raw[12]}}, imm_raw, 1'b0};
            IMM_UPPER:  imm_ext = {{(XLEN-12){1'b0}}, ir[11:0]};
            default:    imm_ext = {{(XLEN-13){imm_raw[12]}}, imm_raw};
        endcase
    end

    // Operand muxes, ALU and result mux.
    always_comb begin
        case (src_a_e'(alu_src_a))
            SRCA_PC:    src_a = pc;
            SRCA_OLDPC: src_a = old_pc;
            SRCA_A:     src_a = a_reg;
            default:    src_a = '0;
        endcase
        case (src_b_e'(alu_src_b))
            SRCB_B:     src_b = b_reg;
            SRCB_IMM:   src_b = imm_ext;
            SRCB_INSTR: src_b = XLEN'(INSTR_BYTES);
            default:    src_b = '0;
        endcase
        case (alu_e'(alu_control))
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLL: alu_result = src_a << src_b[4:0];
            default: alu_result = src_a >> src_b[4:0];
        endcase
        case (result_e'(result_src))
            RES_ALUOUT: result = alu_out;
            RES_MDR:    result = mdr;
            RES_ALU:    result = alu_result;
            default:    result = imm_ext;
        endcase
        seq_addr = adr_src ? result[ADDR_W-1:0] : pc[ADDR_W-1:0];
    end

    assign zero    = (alu_result == '0);
    assign less    = alu_result[XLEN-1];
    assign greater = !alu_result[XLEN-1] && (alu_result != '0);

    // PC and the per-cycle operand/result pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= RESET_PC;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            a_reg   <= rd1;
            b_reg   <= rd2;
            alu_out <= alu_result;
            if (pc_write) pc <= result;
        end
    end

    // Register file write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (reg_write && !(ZERO_REG && rd == 3'd0)) begin
            rf[rd] <= result;
        end
    end

    mc_mem_seq #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_mem_seq (
        .clk        (clk),
        .rst        (rst),
        .mem_start  (mem_start),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .addr       (seq_addr),
        .wdata      (b_reg),
        .pc         (pc),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mdr        (mdr),
        .ir         (ir),
        .old_pc     (old_pc)
    );

endmodule
